// File: rtl/rr_index_arbiter_16_if.sv
// Request/grant bundle for rr_index_arbiter_16.
//   req       : per-source request levels (16)
//   done      : completion pulse from the current owner
//   idx       : registered winner index, drives the downstream 4-to-16 decoder
//   idx_valid : idx holds a live grant; qualifies the decoder output
//   timeout   : one-cycle pulse when the watchdog revokes a grant
//   busy      : arbiter is in its grant state (same as idx_valid)
// master = the request side (sources), slave = the arbiter.
interface rr_index_arbiter_16_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  idx;
  logic        idx_valid;
  logic        timeout;
  logic        busy;

  modport master (
    output req, done,
    input  idx, idx_valid, timeout, busy
  );

  modport slave (
    input  req, done,
    output idx, idx_valid, timeout, busy
  );
endinterface

// File: rtl/rr_index_arbiter_16.sv
// Round-robin arbiter over 16 requesters with a registered 4-bit winner index.
// A grant is held until the owner pulses done, drops its request, or the
// watchdog expires after TIMEOUT cycles (TIMEOUT=0 disables the watchdog).
// After every release the priority pointer moves to the source after the owner,
// and the arbiter spends at least one cycle idle before the next grant.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of rr_index_arbiter_16_if (req/done in; idx/idx_valid/timeout/busy out)
module rr_index_arbiter_16 #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  rr_index_arbiter_16_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // Last cycle index of a grant; only meaningful when the watchdog is enabled.
  localparam logic [7:0] CntLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam bit         WdEn    = (TIMEOUT != 0);

  state_e     state_q;
  logic [3:0] ptr_q;
  logic [3:0] idx_q;
  logic [7:0] cnt_q;
  logic       idx_valid_q;
  logic       timeout_q;

  logic [3:0] winner;
  logic [3:0] cand;
  logic       found;
  logic       expire;
  logic       owner_req;

  // Scan ptr, ptr+1, ... (mod 16) and take the first requester.
  always_comb begin
    winner = 4'd0;
    cand   = 4'd0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    owner_req = bus.req[idx_q];
    expire    = WdEn && (cnt_q == CntLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 4'd0;
      idx_q       <= 4'd0;
      cnt_q       <= 8'd0;
      idx_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (found) begin
            idx_q       <= winner;
            idx_valid_q <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (bus.done || !owner_req || expire) begin
            idx_valid_q <= 1'b0;
            state_q     <= StIdle;
            ptr_q       <= idx_q + 4'd1;
            // done and abandon both outrank the watchdog.
            timeout_q   <= !bus.done && owner_req;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          idx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = idx_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = idx_valid_q;

endmodule
